// File: rtl/iir_decimator.sv
// Averaging decimator: sums N = 2^DECIM_LOG2 valid samples and emits their floor average
// into a 2-entry output FIFO with ready/valid handshake and a sticky overrun flag.
module iir_decimator #(
   parameter int DECIM_LOG2 = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] din,
   input  logic               din_valid,
   output logic signed [15:0] dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               overrun
);

   localparam int AW = 16 + DECIM_LOG2;
   localparam logic [DECIM_LOG2-1:0] CNT_LAST = {DECIM_LOG2{1'b1}};
   localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   logic signed [AW-1:0]         r_acc;
   logic        [DECIM_LOG2-1:0] r_cnt;
   occ_t                         r_occ;
   logic signed [15:0]           r_head;
   logic signed [15:0]           r_tail;
   logic                         r_dout_valid;
   logic                         r_overrun;

   logic signed [AW-1:0]         w_sum;
   logic signed [AW-1:0]         w_avg;
   logic signed [15:0]           w_result;
   logic                         w_push;
   logic                         w_pop;
   logic        [1:0]            w_push_pop;
   occ_t                         w_occ_nxt;
   logic signed [15:0]           w_head_nxt;
   logic signed [15:0]           w_tail_nxt;
   logic                         w_drop;

   // The sum of N 16-bit values always fits AW bits, so the shifted average fits 16 bits.
   assign w_sum      = r_acc + {{DECIM_LOG2{din[15]}}, din};
   assign w_avg      = w_sum >>> DECIM_LOG2;
   assign w_result   = w_avg[15:0];
   assign w_push     = din_valid & (r_cnt == CNT_LAST);
   assign w_pop      = r_dout_valid & dout_ready;
   assign w_push_pop = {w_push, w_pop};

   // Accumulate valid samples; the Nth sample closes the block and restarts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (din_valid) begin
         if (r_cnt == CNT_LAST) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   // Next FIFO state; the head register is what dout presents.
   always_comb begin
      w_occ_nxt  = r_occ;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_drop     = 1'b0;
      case (r_occ)
         OCC_EMPTY: begin
            if (w_push) begin
               w_head_nxt = w_result;
               w_occ_nxt  = OCC_ONE;
            end else begin
               w_occ_nxt  = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            case (w_push_pop)
               2'b11:   w_head_nxt = w_result;
               2'b10: begin
                  w_tail_nxt = w_result;
                  w_occ_nxt  = OCC_FULL;
               end
               2'b01:   w_occ_nxt  = OCC_EMPTY;
               default: w_occ_nxt  = OCC_ONE;
            endcase
         end
         OCC_FULL: begin
            case (w_push_pop)
               2'b11: begin
                  w_head_nxt = r_tail;
                  w_tail_nxt = w_result;
               end
               2'b10:   w_drop = 1'b1;
               2'b01: begin
                  w_head_nxt = r_tail;
                  w_occ_nxt  = OCC_ONE;
               end
               default: w_occ_nxt = OCC_FULL;
            endcase
         end
         default: w_occ_nxt = OCC_EMPTY;
      endcase
   end

   // FIFO storage, registered valid and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ        <= OCC_EMPTY;
         r_head       <= 16'sd0;
         r_tail       <= 16'sd0;
         r_dout_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_occ        <= w_occ_nxt;
         r_head       <= w_head_nxt;
         r_tail       <= w_tail_nxt;
         r_dout_valid <= (w_occ_nxt != OCC_EMPTY);
         r_overrun    <= r_overrun | w_drop;
      end
   end

   assign dout       = r_head;
   assign dout_valid = r_dout_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_iir_decimator.sv
// Directed plus random bench for iir_decimator (N=8) against a queue-based average model.
module tb_iir_decimator;

   localparam int DL = 3;
   localparam int N  = 1 << DL;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] din = 16'sd0;
   logic               din_valid = 1'b0;
   logic signed [15:0] dout;
   logic               dout_valid;
   logic               dout_ready = 1'b0;
   logic               overrun;

   int checks   = 0;
   int failures = 0;

   // Reference model state: running sum of the current block, outputs waiting, overrun flag.
   int m_sum = 0;
   int m_cnt = 0;
   int m_q[$];
   bit m_ovr = 1'b0;

   iir_decimator #(.DECIM_LOG2(DL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   function automatic int floor_avg(int s);
      if (s >= 0) return s / N;
      else        return -((-s + N - 1) / N);
   endfunction

   task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sum = 0;
      m_cnt = 0;
      m_q.delete();
      m_ovr = 1'b0;
   endtask

   task automatic model_edge(int d, bit v, bit r);
      bit pop;
      bit push;
      int res;
      pop  = (m_q.size() > 0) && r;
      push = 1'b0;
      res  = 0;
      if (v) begin
         m_sum += d;
         m_cnt++;
         if (m_cnt == N) begin
            push  = 1'b1;
            res   = floor_avg(m_sum);
            m_sum = 0;
            m_cnt = 0;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < 2) m_q.push_back(res);
         else                m_ovr = 1'b1;
      end
   endtask

   task automatic compare_model();
      chk("dout_valid", 32'(dout_valid), 32'(m_q.size() > 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_q.size() > 0) chk("dout", dout, m_q[0]);
   endtask

   // Apply inputs now, clock once, then check against the model.
   task automatic drive_edge(int d, bit v, bit r);
      din        = 16'(d);
      din_valid  = v;
      dout_ready = r;
      @(posedge clk);
      model_edge(d, v, r);
      #1;
      compare_model();
   endtask

   task automatic step(int d, bit v, bit r);
      @(negedge clk);
      drive_edge(d, v, r);
   endtask

   task automatic block(int d, int n, bit r);
      for (int i = 0; i < n; i++) step(d, 1'b1, r);
   endtask

   task automatic drain(int n);
      for (int i = 0; i < n; i++) step(0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [15:0] rv;
      int          d;

      #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_overrun", 32'(overrun), 0);
      model_reset();

      // First sample lands on the first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      drive_edge(1000, 1'b1, 1'b1);
      block(1000, N - 1, 1'b1);
      chk("avg1000", dout, 1000);
      chk("avg1000_valid", 32'(dout_valid), 1);
      step(0, 1'b0, 1'b1);
      chk("avg1000_once", 32'(dout_valid), 0);

      block(0, 7, 1'b1);
      step(-1, 1'b1, 1'b1);
      chk("floor_neg1", dout, -1);
      block(-32768, N, 1'b1);
      chk("min", dout, -32768);
      block(32767, N, 1'b1);
      chk("max", dout, 32767);
      for (int i = 0; i < N; i++) step((i % 2 == 0) ? 5 : -5, 1'b1, 1'b1);
      chk("alt", dout, 0);
      drain(2);

      for (int i = 0; i < N; i++) begin
         step(200, 1'b1, 1'b0);
         step(7777, 1'b0, 1'b0);
      end
      chk("gapped", dout, 200);
      drain(2);
      chk("gapped_single", 32'(dout_valid), 0);

      block(10, N, 1'b0);
      block(20, N, 1'b0);
      block(30, N - 1, 1'b0);
      step(30, 1'b1, 1'b1);
      chk("fullpp_head", dout, 20);
      chk("fullpp_ovr", 32'(overrun), 0);
      step(0, 1'b0, 1'b1);
      chk("fullpp_tail", dout, 30);
      drain(2);

      block(10, N, 1'b0);
      block(20, N, 1'b0);
      block(30, N, 1'b0);
      chk("bp_ovr", 32'(overrun), 1);
      chk("bp_head", dout, 10);
      step(0, 1'b0, 1'b1);
      chk("bp_second", dout, 20);
      step(0, 1'b0, 1'b1);
      chk("bp_empty", 32'(dout_valid), 0);
      block(40, N, 1'b0);

      // Asynchronous reset between edges with a partial block and a pending output.
      block(500, 5, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_dout", dout, 0);
      chk("arst_valid", 32'(dout_valid), 0);
      chk("arst_overrun", 32'(overrun), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive_edge(100, 1'b1, 1'b1);
      block(100, N - 1, 1'b1);
      chk("post_rst", dout, 100);
      drain(2);

      for (int i = 0; i < 400; i++) begin
         rv = 16'($urandom);
         d  = int'($signed(rv));
         step(d, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
      end
      drain(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iir_decimator.md
IIR_DECIMATOR -- requirements
Module: iir_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 3, log2 of decimation factor N = 2^DECIM_LOG2 (legal range 1..6).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port din  input  16  signed Q-format sample from the upstream biquad output (dout of the biquad stage).
REQ-005 SHALL have port din_valid  input  1  din is a new sample this cycle.
REQ-006 SHALL have port dout  output  16  signed averaged/decimated sample (head of output buffer).
REQ-007 SHALL have port dout_valid  output  1  dout holds an unconsumed result.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 SHALL have port overrun  output  1  sticky flag: a result was dropped because the buffer was full.

Function
REQ-010 SHALL keep a signed accumulator of width 16+DECIM_LOG2 and a sample counter of width DECIM_LOG2.
REQ-011 SHALL, on a cycle with din_valid=1 and counter<N-1, set acc <= acc + din and increment counter.
REQ-012 SHALL, on a cycle with din_valid=1 and counter=N-1, form result = (acc + din) >>> DECIM_LOG2 (arithmetic shift, floor rounding), clear acc to 0 and counter to 0 in the same edge.
REQ-013 SHALL ignore din entirely when din_valid=0 (acc and counter hold).
REQ-014 SHALL never saturate; the result always fits 16 bits by construction (average of N 16-bit values).
REQ-015 SHALL hold results in a 2-entry FIFO; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-016 SHALL drive dout_valid=1 exactly when occupancy>0, and dout = oldest entry; dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-017 SHALL pop the head on a cycle where dout_valid=1 and dout_ready=1.
REQ-018 SHALL present a new result on dout/dout_valid the cycle after the edge that captured the Nth sample when the FIFO was EMPTY (1-cycle latency).
REQ-019 SHALL, on simultaneous push and pop, keep occupancy unchanged and accept the new result, including when FULL.
REQ-020 SHALL, on push while FULL with no pop, discard the new result, keep stored entries unchanged, and set overrun=1.
REQ-021 SHALL keep overrun set until reset; the accumulator/counter SHALL continue operating normally after an overrun.
REQ-022 SHALL treat dout_ready=1 while EMPTY as a no-op.

Reset
REQ-023 SHALL, while rst_n=0, force acc=0, counter=0, occupancy EMPTY, dout_valid=0, dout=0, overrun=0, regardless of clk.
REQ-024 SHALL discard any partial accumulation on reset; the first result after rst_n deasserts uses the next N valid samples only.
REQ-025 SHALL accept din_valid on the first rising edge after rst_n deasserts.

Verification (DECIM_LOG2=3, N=8)
REQ-026 SHALL verify: din=1000, din_valid=1 for 8 cycles, dout_ready=1 -> dout=1000, dout_valid=1 for exactly one cycle, one cycle after the 8th sample edge.
REQ-027 SHALL verify rounding/extremes: 7x0 then 1x(-1) -> dout=-1; 8x(-32768) -> -32768; 8x32767 -> 32767; alternating +5/-5 -> 0.
REQ-028 SHALL verify gapped input: 8 samples of 200 with din_valid toggling 1/0 -> single result 200 after 8th valid sample; invalid cycles do not count.
REQ-029 SHALL verify backpressure: dout_ready=0, 24 valid samples in three blocks of values 10, 20, 30 -> FIFO holds 10 then 20, overrun=1 after 24th sample; then dout_ready=1 yields 10, 20, and dout_valid=0.
REQ-030 SHALL verify FULL with simultaneous pop/push: FIFO holds 10,20; 8th sample of block 30 arrives on a cycle with dout_ready=1 -> 10 consumed, FIFO holds 20,30, overrun stays 0.
REQ-031 SHALL verify reset mid-operation: 5 samples of 500, assert rst_n=0 asynchronously between edges -> all outputs zero immediately; after release, 8 samples of 100 -> dout=100.
